// File: rtl/ro_pair_counter.sv
// Ring-oscillator pair measurement stage.
// Settles a selected RO pair, counts edges of each over a window, compares.
module ro_pair_counter #(
   parameter int CNT_WIDTH     = 16,
   parameter int WINDOW_CYCLES = 1000,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 ro_a,
   input  logic                 ro_b,
   output logic                 ro_en,
   output logic                 busy,
   output logic                 done,
   output logic                 response,
   output logic                 tie,
   output logic [CNT_WIDTH-1:0] count_a,
   output logic [CNT_WIDTH-1:0] count_b
);

   localparam int TMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ?
                         WINDOW_CYCLES : SETTLE_CYCLES;
   localparam int TW = $clog2(TMAX + 1);

   localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      COUNT   = 2'd2,
      COMPARE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           sync_a_q, sync_a_d;
   logic [2:0]           sync_b_q, sync_b_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_WIDTH-1:0] cnt_b_q, cnt_b_d;
   logic [CNT_WIDTH-1:0] count_a_q, count_a_d;
   logic [CNT_WIDTH-1:0] count_b_q, count_b_d;
   logic                 ro_en_q, ro_en_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 response_q, response_d;
   logic                 tie_q, tie_d;

   logic                 edge_a, edge_b;
   logic [CNT_WIDTH-1:0] cnt_a_inc, cnt_b_inc;

   assign edge_a = sync_a_q[1] & ~sync_a_q[2];
   assign edge_b = sync_b_q[1] & ~sync_b_q[2];

   // Saturating next-count values used during the window.
   always_comb begin
      cnt_a_inc = cnt_a_q;
      cnt_b_inc = cnt_b_q;
      if (edge_a && (cnt_a_q != CNT_MAX)) cnt_a_inc = cnt_a_q + 1'b1;
      if (edge_b && (cnt_b_q != CNT_MAX)) cnt_b_inc = cnt_b_q + 1'b1;
   end

   // Next-state logic: synchronizers, sequencing, counting and result capture.
   always_comb begin
      sync_a_d   = {sync_a_q[1:0], ro_a};
      sync_b_d   = {sync_b_q[1:0], ro_b};
      state_d    = state_q;
      timer_d    = timer_q;
      cnt_a_d    = cnt_a_q;
      cnt_b_d    = cnt_b_q;
      count_a_d  = count_a_q;
      count_b_d  = count_b_q;
      ro_en_d    = ro_en_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      response_d = response_q;
      tie_d      = tie_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETTLE;
               timer_d = '0;
               cnt_a_d = '0;
               cnt_b_d = '0;
               ro_en_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         SETTLE: begin
            if (timer_q == SET_LAST) begin
               state_d = COUNT;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         COUNT: begin
            cnt_a_d = cnt_a_inc;
            cnt_b_d = cnt_b_inc;
            if (timer_q == WIN_LAST) begin
               state_d    = COMPARE;
               ro_en_d    = 1'b0;
               done_d     = 1'b1;
               count_a_d  = cnt_a_inc;
               count_b_d  = cnt_b_inc;
               response_d = (cnt_a_inc > cnt_b_inc);
               tie_d      = (cnt_a_inc == cnt_b_inc);
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         COMPARE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops ro_en asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sync_a_q   <= '0;
         sync_b_q   <= '0;
         timer_q    <= '0;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
         count_a_q  <= '0;
         count_b_q  <= '0;
         ro_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         response_q <= 1'b0;
         tie_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_a_q   <= sync_a_d;
         sync_b_q   <= sync_b_d;
         timer_q    <= timer_d;
         cnt_a_q    <= cnt_a_d;
         cnt_b_q    <= cnt_b_d;
         count_a_q  <= count_a_d;
         count_b_q  <= count_b_d;
         ro_en_q    <= ro_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         response_q <= response_d;
         tie_q      <= tie_d;
      end
   end

   assign ro_en    = ro_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign response = response_q;
   assign tie      = tie_q;
   assign count_a  = count_a_q;
   assign count_b  = count_b_q;

endmodule

// File: tb/tb_ro_pair_counter.sv
// Bench for ro_pair_counter: two instances (default and 4-bit/short window).
// Expected counts come from rising transitions of the clk-sampled RO waveforms.
module tb_ro_pair_counter;

   localparam int S  = 8;
   localparam int W  = 1000;
   localparam int S2 = 8;
   localparam int W2 = 100;
   localparam int NS = 40000;

   logic clk = 1'b1;
   logic rst_n;
   logic start, start2;
   logic ro_a = 1'b0;
   logic rb = 1'b0;
   logic ro_b, ro_b2;
   logic same = 1'b0;
   logic b2_on = 1'b0;
   int   pa = 40;
   int   pb = 50;

   logic        ro_en, busy, done, response, tie;
   logic [15:0] count_a, count_b;
   logic        ro_en2, busy2, done2, response2, tie2;
   logic [3:0]  count_a2, count_b2;

   int vectors = 0;
   int errs = 0;
   int cyc = 0;
   bit sa [NS];
   bit sb [NS];
   bit sb2 [NS];

   assign ro_b  = same ? ro_a : rb;
   assign ro_b2 = b2_on ? ro_b : 1'b0;

   ro_pair_counter #(.CNT_WIDTH(16), .WINDOW_CYCLES(W),
                     .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en),
      .busy(busy), .done(done), .response(response),
      .tie(tie), .count_a(count_a), .count_b(count_b)
   );

   ro_pair_counter #(.CNT_WIDTH(4), .WINDOW_CYCLES(W2),
                     .SETTLE_CYCLES(S2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .ro_a(ro_a), .ro_b(ro_b2), .ro_en(ro_en2),
      .busy(busy2), .done(done2), .response(response2),
      .tie(tie2), .count_a(count_a2), .count_b(count_b2)
   );

   // Posedges at multiples of 10; RO edges always on odd times.
   initial forever #5 clk = ~clk;

   function automatic int lo_half(input int p);
      int h = p / 2;
      return (h % 2 != 0) ? h - 1 : h;
   endfunction

   function automatic int hi_half(input int p);
      int h = p / 2;
      return (h % 2 != 0) ? h + 1 : h;
   endfunction

   initial begin
      #1;
      forever begin
         #(lo_half(pa)); ro_a = ~ro_a;
         #(hi_half(pa)); ro_a = ~ro_a;
      end
   end

   initial begin
      #1;
      forever begin
         #(lo_half(pb)); rb = ~rb;
         #(hi_half(pb)); rb = ~rb;
      end
   end

   // Record what the first synchronizer stage sees at every clock edge.
   always @(posedge clk) begin
      if (cyc < NS) begin
         sa[cyc]  = ro_a;
         sb[cyc]  = ro_b;
         sb2[cyc] = ro_b2;
      end
      cyc = cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit smp(input int s, input int e);
      if (s == 0) return sa[e];
      if (s == 1) return sb[e];
      return sb2[e];
   endfunction

   // Rising transitions seen after the two-flop synchronizer delay,
   // counted over the window cycles, clipped at the counter maximum.
   function automatic int exp_cnt(input int s, input int k, input int st,
                                  input int wn, input int nb);
      int c = 0;
      int mx = (1 << nb) - 1;
      for (int e = k + st + 1; e <= k + st + wn; e++)
         if (smp(s, e - 2) && !smp(s, e - 3)) c++;
      return (c > mx) ? mx : c;
   endfunction

   task automatic set_start(input int which, input logic v);
      if (which != 0) start2 = v;
      else start = v;
   endtask

   task automatic check_out(input int which, input int k);
      int ea, eb;
      if (which == 0) begin
         ea = exp_cnt(0, k, S, W, 16);
         eb = exp_cnt(1, k, S, W, 16);
         chk("count_a", 32'(count_a), ea);
         chk("count_b", 32'(count_b), eb);
         chk("response", 32'(response), 32'(ea > eb));
         chk("tie", 32'(tie), 32'(ea == eb));
         chk("busy_in_done", 32'(busy), 1);
      end else begin
         ea = exp_cnt(0, k, S2, W2, 4);
         eb = exp_cnt(2, k, S2, W2, 4);
         chk("count_a2", 32'(count_a2), ea);
         chk("count_b2", 32'(count_b2), eb);
         chk("response2", 32'(response2), 32'(ea > eb));
         chk("tie2", 32'(tie2), 32'(ea == eb));
      end
   endtask

   // One full measurement started from idle; checks latency, ro_en
   // duration and the result. Optionally pokes start mid-window.
   task automatic run_meas(input int which, input int pulse_mid);
      int k, st, wn, en, got;
      st = (which != 0) ? S2 : S;
      wn = (which != 0) ? W2 : W;
      k = cyc;
      set_start(which, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(which, 1'b0);
      en = 0;
      got = 0;
      for (int i = 0; i < st + wn + 20; i++) begin
         if (which == 0 && pulse_mid != 0)
            start = (i == st + wn / 2);
         if ((which != 0) ? ro_en2 : ro_en) en++;
         if ((which != 0) ? done2 : done) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_seen", got, 1);
      chk("done_latency", cyc, k + st + wn + 1);
      chk("ro_en_cycles", en, st + wn);
      check_out(which, k);
      @(negedge clk);
      chk("done_pulse_end",
          32'((which != 0) ? done2 : done), 0);
   endtask

   int flag, k, d1, d2, got;
   logic r1;

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      start2 = 1'b0;

      // Reset held: start toggling must not wake the block.
      flag = 0;
      repeat (12) begin
         @(negedge clk);
         start = ~start;
         #1;
         if (ro_en || busy || done || response || tie ||
             count_a != 0 || count_b != 0 || ro_en2 || done2)
            flag = 1;
      end
      chk("reset_outputs", flag, 0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_ro_en", 32'(ro_en), 0);
      chk("idle_busy", 32'(busy), 0);

      // A faster than B.
      pa = 40; pb = 50;
      run_meas(0, 0);

      // Random oscillator periods (all slower than clk/2).
      for (int r = 0; r < 3; r++) begin
         pa = 2 * 2 * $urandom_range(6, 30);
         pb = 2 * 2 * $urandom_range(6, 30);
         run_meas(0, 0);
      end

      // Identical in-phase sources.
      pa = 60;
      same = 1'b1;
      repeat (3) @(negedge clk);
      run_meas(0, 0);
      chk("tie_flag", 32'(tie), 1);
      same = 1'b0;

      // Start pulsed during COUNT is neither queued nor clears counters.
      pa = 44; pb = 36;
      run_meas(0, 1);
      flag = 0;
      for (int i = 0; i < S + W + 5; i++) begin
         @(negedge clk);
         if (done || busy) flag = 1;
      end
      chk("no_extra_done", flag, 0);

      // Start held high: back-to-back measurements.
      pa = 28; pb = 52;
      k = cyc;
      start = 1'b1;
      got = 0;
      for (int i = 0; i < S + W + 20; i++) begin
         @(negedge clk);
         if (done) begin got = 1; break; end
      end
      chk("b2b_done1", got, 1);
      d1 = cyc;
      chk("b2b_latency1", d1, k + S + W + 1);
      check_out(0, k);
      r1 = response;
      flag = 0;
      got = 0;
      for (int i = 0; i < S + W + 20; i++) begin
         @(negedge clk);
         if (done) begin got = 1; break; end
         if (response !== r1) flag = 1;
      end
      start = 1'b0;
      d2 = cyc;
      chk("b2b_done2", got, 1);
      chk("b2b_spacing", d2 - d1, S + W + 2);
      chk("b2b_resp_hold", flag, 0);
      check_out(0, k + S + W + 2);
      repeat (3) @(negedge clk);

      // Saturation: 4-bit counters, B idle.
      pa = 40; pb = 50;
      b2_on = 1'b0;
      run_meas(1, 0);
      chk("sat_count_a", 32'(count_a2), 15);
      // Both saturated.
      b2_on = 1'b1;
      run_meas(1, 0);
      chk("sat_tie", 32'(tie2), 1);
      chk("sat_response", 32'(response2), 0);

      // Reset mid-window.
      pa = 40; pb = 60;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (S + 500) @(negedge clk);
      chk("pre_reset_ro_en", 32'(ro_en), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_ro_en", 32'(ro_en), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_count_a", 32'(count_a), 0);
      flag = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || ro_en) flag = 1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done || ro_en) flag = 1;
      end
      chk("reset_no_done", flag, 0);
      run_meas(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errs);
      $finish;
   end

endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Measurement stage directly downstream of the ring oscillators.
- Enables one selected pair of oscillators and lets them settle.
- Counts rising edges of each oscillator over a fixed window of system clocks, then compares the two counts to produce one PUF response bit.
- Sits between the RO array/mux (consumes their ro_out, drives their enable) and the challenge/response controller.

Parameters:
- CNT_WIDTH, 16, width of each edge counter and of the count outputs.
- WINDOW_CYCLES, 1000, clk cycles spent counting; ≥1.
- SETTLE_CYCLES, 8, clk cycles with oscillators enabled before counting starts; ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a measurement; sampled only in IDLE.
- ro_a  input  1  oscillator A output, asynchronous to clk.
- ro_b  input  1  oscillator B output, asynchronous to clk.
- ro_en  output  1  enable to both selected oscillators.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when result is valid.
- response  output  1  1 if count_a > count_b, else 0.
- tie  output  1  1 if count_a == count_b.
- count_a  output  CNT_WIDTH  final edge count of ro_a.
- count_b  output  CNT_WIDTH  final edge count of ro_b.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, synchronizers and counters cleared.
- Input capture:
  - ro_a and ro_b each pass through a 2-flop synchronizer, then a third flop for rising-edge detect (sync2 & ~sync3).
  - Source frequency must be < clk/2. Faster inputs alias; this is a stated system constraint, not detected.
- FSM: IDLE -> SETTLE -> COUNT -> COMPARE -> IDLE.
  - IDLE: ro_en=0, busy=0. start=1 at a rising edge moves to SETTLE, clears both counters and the internal cycle timer. response, tie, count_a and count_b hold the previous result until COMPARE overwrites them.
  - SETTLE: ro_en=1, busy=1. Lasts exactly SETTLE_CYCLES cycles. Edges are ignored.
  - COUNT: ro_en=1, busy=1. Lasts exactly WINDOW_CYCLES cycles. Each cycle, each counter increments by 1 if its edge-detect is high. Counters saturate at all-ones; no wrap.
  - COMPARE: ro_en=0, busy=1, one cycle.
    - Registers count_a/count_b from the counters.
    - Sets response = (cnt_a > cnt_b) and tie = (cnt_a == cnt_b).
    - Pulses done. Next state IDLE.
- Latency:
  - If start is sampled at edge k, ro_en is high from edge k to edge k+SETTLE_CYCLES+WINDOW_CYCLES.
  - done is high for the cycle following edge k+SETTLE_CYCLES+WINDOW_CYCLES.
  - Outputs are valid in the same cycle as done and hold until the next COMPARE.
- start while busy is ignored; it is not queued. start held high continuously gives back-to-back measurements with one IDLE cycle between them.
- Edges still in the synchronizer pipeline when COUNT ends are discarded. The same applies to both channels, so the comparison stays symmetric.
- Reset asserted mid-measurement: ro_en drops immediately (asynchronously), all state clears, and no done is issued.
- Both counters saturated: tie=1, response=0.

Test Plan:
- Reset behaviour: hold rst_n=0 while toggling start -> all outputs 0, ro_en never rises. Deassert rst_n -> still idle until start.
- A faster than B: SETTLE_CYCLES=8, WINDOW_CYCLES=1000, clk period 10 ns, ro_a period 40 ns, ro_b period 50 ns, pulse start -> done at start+1009 edges, count_a=250±1, count_b=200±1, response=1, tie=0. ro_en high for exactly 1008 cycles.
- Tie: identical 60 ns sources, in phase -> count_a==count_b, tie=1, response=0.
- Saturation: CNT_WIDTH=4, WINDOW_CYCLES=100, ro_a period 40 ns, ro_b idle low -> count_a=15, count_b=0, response=1.
- Start handling: pulse start during COUNT -> no extra done and no counter clear. Then hold start high for two measurements -> two done pulses separated by WINDOW_CYCLES+SETTLE_CYCLES+2 cycles. response holds between them.
- Reset mid-COUNT: drop rst_n at window cycle 500 -> ro_en=0 within the same cycle, no done. A new start after release gives a correct full-window result.
